// File: rtl/pipe_flush_ctrl.sv
// Pipeline hazard/redirect controller: per-stage flush/stall vectors, precise
// exception drain/redirect sequencing, per-stage valid tracking and redirect counters.
module pipe_flush_ctrl #(
   parameter int unsigned NUM_STAGES    = 5,
   parameter int unsigned RESOLVE_STAGE = 3,
   parameter int unsigned REG_W         = 5,
   parameter int unsigned CNT_W         = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pcsrc_i,
   input  logic                  exc_i,
   input  logic                  mc_busy_i,
   input  logic                  memread_exe_i,
   input  logic [REG_W-1:0]      rt_exe_i,
   input  logic [REG_W-1:0]      rs_dec_i,
   input  logic [REG_W-1:0]      rt_dec_i,
   output logic [NUM_STAGES-1:0] flush_o,
   output logic [NUM_STAGES-1:0] stall_o,
   output logic [1:0]            pc_sel_o,
   output logic [NUM_STAGES-1:0] valid_o,
   output logic                  busy_o,
   output logic [CNT_W-1:0]      branch_cnt_o,
   output logic [CNT_W-1:0]      exc_cnt_o
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      DRAIN    = 2'd1,
      REDIRECT = 2'd2
   } state_e;

   function automatic logic [NUM_STAGES-1:0] low_bits(input int unsigned n);
      logic [NUM_STAGES-1:0] m;
      m = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         if (k < n) m[k] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [2:0]            DRAIN_LEN = 3'(NUM_STAGES - 1 - RESOLVE_STAGE);
   localparam logic [NUM_STAGES-1:0] EXC_MASK  = low_bits(RESOLVE_STAGE + 1);
   localparam logic [NUM_STAGES-1:0] BR_MASK   = low_bits(RESOLVE_STAGE);

   state_e                state_q, state_d;
   logic [2:0]            drain_q, drain_d;
   logic [NUM_STAGES-1:0] valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic [CNT_W-1:0]      bcnt_q, bcnt_d;
   logic [CNT_W-1:0]      ecnt_q, ecnt_d;
   logic                  load_use;

   assign load_use = memread_exe_i && (rt_exe_i != '0) &&
                     ((rt_exe_i == rs_dec_i) || (rt_exe_i == rt_dec_i));

   always_comb begin
      flush_o  = '0;
      stall_o  = '0;
      pc_sel_o = 2'b00;
      state_d  = state_q;
      drain_d  = drain_q;
      bcnt_d   = bcnt_q;
      ecnt_d   = ecnt_q;
      valid_d  = valid_q;

      unique case (state_q)
         RUN: begin
            if (exc_i) begin
               flush_o  = EXC_MASK;
               pc_sel_o = 2'b11;
               if (ecnt_q != '1) ecnt_d = ecnt_q + CNT_W'(1);
               if (DRAIN_LEN == 3'd0) begin
                  state_d = REDIRECT;
               end else begin
                  state_d = DRAIN;
                  drain_d = DRAIN_LEN;
               end
            end else if (pcsrc_i) begin
               flush_o  = BR_MASK;
               pc_sel_o = 2'b01;
               if (bcnt_q != '1) bcnt_d = bcnt_q + CNT_W'(1);
            end else if (mc_busy_i) begin
               stall_o[2:0] = 3'b111;
               flush_o[3]   = 1'b1;
            end else if (load_use) begin
               stall_o[1:0] = 2'b11;
               flush_o[2]   = 1'b1;
            end
         end
         DRAIN: begin
            flush_o    = EXC_MASK;
            stall_o[0] = 1'b1;
            pc_sel_o   = 2'b11;
            drain_d    = drain_q - 3'd1;
            if (drain_q <= 3'd1) state_d = REDIRECT;
         end
         REDIRECT: begin
            pc_sel_o   = 2'b10;
            flush_o[0] = 1'b1;
            state_d    = RUN;
         end
         default: state_d = RUN;
      endcase

      busy_d = (state_d != RUN);

      // A stalled upstream stage inserts a bubble into the stage after it.
      valid_d[0] = flush_o[0] ? 1'b0 : (stall_o[0] ? valid_q[0] : 1'b1);
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
         if (flush_o[k])        valid_d[k] = 1'b0;
         else if (stall_o[k])   valid_d[k] = valid_q[k];
         else if (stall_o[k-1]) valid_d[k] = 1'b0;
         else                   valid_d[k] = valid_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         drain_q <= '0;
         valid_q <= '0;
         busy_q  <= 1'b0;
         bcnt_q  <= '0;
         ecnt_q  <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         bcnt_q  <= bcnt_d;
         ecnt_q  <= ecnt_d;
      end
   end

   assign valid_o      = valid_q;
   assign busy_o       = busy_q;
   assign branch_cnt_o = bcnt_q;
   assign exc_cnt_o    = ecnt_q;

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Scoreboard bench for pipe_flush_ctrl: a driver pushes model expectations per
// cycle, a monitor pops and compares them against the DUT outputs.
module tb_pipe_flush_ctrl;

   localparam int NS  = 5;
   localparam int RS  = 3;
   localparam int RW  = 5;
   localparam int CW  = 4;
   localparam int DL  = NS - 1 - RS;
   localparam int MAXC = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          pcsrc_i, exc_i, mc_busy_i, memread_exe_i;
   logic [RW-1:0] rt_exe_i, rs_dec_i, rt_dec_i;
   logic [NS-1:0] flush_o, stall_o, valid_o;
   logic [1:0]    pc_sel_o;
   logic          busy_o;
   logic [CW-1:0] branch_cnt_o, exc_cnt_o;

   always #5 clk = ~clk;

   pipe_flush_ctrl #(
      .NUM_STAGES   (NS),
      .RESOLVE_STAGE(RS),
      .REG_W        (RW),
      .CNT_W        (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pcsrc_i      (pcsrc_i),
      .exc_i        (exc_i),
      .mc_busy_i    (mc_busy_i),
      .memread_exe_i(memread_exe_i),
      .rt_exe_i     (rt_exe_i),
      .rs_dec_i     (rs_dec_i),
      .rt_dec_i     (rt_dec_i),
      .flush_o      (flush_o),
      .stall_o      (stall_o),
      .pc_sel_o     (pc_sel_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o),
      .branch_cnt_o (branch_cnt_o),
      .exc_cnt_o    (exc_cnt_o)
   );

   typedef struct packed {
      logic [NS-1:0] fl;
      logic [NS-1:0] st;
      logic [1:0]    pc;
      logic [NS-1:0] v;
      logic          busy;
      logic [CW-1:0] bc;
      logic [CW-1:0] ec;
   } rec_t;

   rec_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: drain cycles remaining, pending redirect, valid array, counts.
   int            m_drain;
   bit            m_redir;
   logic [NS-1:0] m_valid;
   int            m_bc, m_ec;

   function automatic logic [NS-1:0] lowmask(input int n);
      return NS'((64'd1 << n) - 64'd1);
   endfunction

   task automatic model_reset();
      m_drain = 0;
      m_redir = 0;
      m_valid = '0;
      m_bc    = 0;
      m_ec    = 0;
   endtask

   task automatic step(input bit exc, input bit pcs, input bit mc, input bit mr,
                       input logic [RW-1:0] rte, input logic [RW-1:0] rsd,
                       input logic [RW-1:0] rtd);
      logic [NS-1:0] f, s, nv;
      logic [1:0]    pc;
      bit            running, lu;
      rec_t          r;
      @(negedge clk);
      rst_n = 1'b1;
      exc_i = exc; pcsrc_i = pcs; mc_busy_i = mc; memread_exe_i = mr;
      rt_exe_i = rte; rs_dec_i = rsd; rt_dec_i = rtd;
      f = '0; s = '0; pc = 2'b00;
      running = (m_drain == 0) && !m_redir;
      lu = mr && (rte != 0) && ((rte == rsd) || (rte == rtd));
      if (m_drain > 0) begin
         f = lowmask(RS + 1); s = 1; pc = 2'b11;
      end else if (m_redir) begin
         f = 1; pc = 2'b10;
      end else if (exc) begin
         f = lowmask(RS + 1); pc = 2'b11;
      end else if (pcs) begin
         f = lowmask(RS); pc = 2'b01;
      end else if (mc) begin
         s = NS'(7); f = NS'(8);
      end else if (lu) begin
         s = NS'(3); f = NS'(4);
      end
      r.fl = f; r.st = s; r.pc = pc; r.v = m_valid; r.busy = !running;
      r.bc = CW'(m_bc); r.ec = CW'(m_ec);
      exp_q.push_back(r);
      for (int k = 0; k < NS; k++) begin
         if (f[k])                nv[k] = 1'b0;
         else if (s[k])           nv[k] = m_valid[k];
         else if (k == 0)         nv[k] = 1'b1;
         else if (s[k-1])         nv[k] = 1'b0;
         else                     nv[k] = m_valid[k-1];
      end
      m_valid = nv;
      if (running && exc) begin
         if (m_ec < MAXC) m_ec++;
         if (DL == 0) m_redir = 1; else m_drain = DL;
      end else if (running && pcs) begin
         if (m_bc < MAXC) m_bc++;
      end else if (m_drain > 0) begin
         m_drain--;
         if (m_drain == 0) m_redir = 1;
      end else if (m_redir) begin
         m_redir = 0;
      end
   endtask

   task automatic reset_now();
      rec_t r;
      @(negedge clk);
      rst_n = 1'b0;
      exc_i = 0; pcsrc_i = 0; mc_busy_i = 0; memread_exe_i = 0;
      rt_exe_i = '0; rs_dec_i = '0; rt_dec_i = '0;
      model_reset();
      r = '0;
      exp_q.push_back(r);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0);
   endtask

   initial begin : monitor
      rec_t e, a;
      forever begin
         @(negedge clk);
         #2;
         cyc++;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a.fl = flush_o; a.st = stall_o; a.pc = pc_sel_o; a.v = valid_o;
            a.busy = busy_o; a.bc = branch_cnt_o; a.ec = exc_cnt_o;
            total++;
            if (a !== e) begin
               bad++;
               $display("FAIL cyc%0d outputs: got fl=%b st=%b pc=%b v=%b busy=%b bc=%0d ec=%0d, want fl=%b st=%b pc=%b v=%b busy=%b bc=%0d ec=%0d",
                        cyc, a.fl, a.st, a.pc, a.v, a.busy, a.bc, a.ec,
                        e.fl, e.st, e.pc, e.v, e.busy, e.bc, e.ec);
            end
         end
      end
   end

   initial begin : driver
      int x;
      rst_n = 1'b0;
      exc_i = 0; pcsrc_i = 0; mc_busy_i = 0; memread_exe_i = 0;
      rt_exe_i = '0; rs_dec_i = '0; rt_dec_i = '0;
      model_reset();
      reset_now();
      idle(1);
      step(0, 1, 0, 0, '0, '0, '0);
      idle(6);
      step(0, 0, 0, 1, 5'd5, 5'd5, 5'd1);
      step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
      step(0, 0, 0, 1, 5'd7, 5'd2, 5'd7);
      step(1, 0, 0, 0, '0, '0, '0);
      idle(4);
      step(1, 1, 0, 0, '0, '0, '0);
      step(0, 1, 0, 0, '0, '0, '0);
      step(1, 1, 1, 0, '0, '0, '0);
      idle(3);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, '0, '0, '0);
      idle(2);
      step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0);
      step(1, 0, 0, 0, '0, '0, '0);
      reset_now();
      idle(3);
      for (int i = 0; i < 500; i++) begin
         x = int'($urandom_range(0, 99));
         if (x < 2) reset_now();
         else step(($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), $urandom_range(0, 1) == 1,
                   RW'($urandom_range(0, 3)), RW'($urandom_range(0, 3)),
                   RW'($urandom_range(0, 3)));
      end
      idle(2);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
